// File: rtl/video_timing_decoder.sv
// Video timing decoder: rebuilds x/y from de/hsync/vsync and locks onto stable frame geometry.
// Optional build macro VTD_POLARITY_DETECT_EN learns sync polarity from the levels seen at de rise.
module video_timing_decoder #(
  parameter int unsigned WIDTH       = 12,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             de,
  input  logic             hsync,
  input  logic             vsync,
  output logic [WIDTH-1:0] x,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] h_active,
  output logic [WIDTH-1:0] v_active,
  output logic             locked,
  output logic             frame_start,
  output logic             lock_err
);

  localparam logic [1:0]       StSearch   = 2'd0;
  localparam logic [1:0]       StMeasure  = 2'd1;
  localparam logic [1:0]       StCheck    = 2'd2;
  localparam logic [1:0]       StLocked   = 2'd3;
  localparam logic [WIDTH-1:0] MaxCnt     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] One        = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]       LockFrames = 4'(LOCK_FRAMES);

  logic             de_q, hs_q, vs_q;
  logic             hs_act, hs_act_prev, vs_act, vs_act_prev, pol_change;
  logic             de_fall, hs_edge, vs_edge, glitch, ovf;
  logic [WIDTH-1:0] line_len, lines, frame_h;
  logic             line_bad, lock_line_bad, frame_match;
  logic [1:0]       state_q, state_d;
  logic [3:0]       match_q, match_d;
  logic [WIDTH-1:0] cur_h_q, cur_h_d;
  logic             cur_vld_q, cur_vld_d, cur_ok_q, cur_ok_d;
  logic [WIDTH-1:0] x_d, y_d, h_act_d, v_act_d;
  logic             lock_err_d;

`ifdef VTD_POLARITY_DETECT_EN
  logic de_rise, hs_inact_q, vs_inact_q;

  assign de_rise     = de & ~de_q;
  assign hs_act      = hsync ^ hs_inact_q;
  assign hs_act_prev = hs_q ^ hs_inact_q;
  assign vs_act      = vsync ^ vs_inact_q;
  assign vs_act_prev = vs_q ^ vs_inact_q;
  assign pol_change  = de_rise & ((hsync != hs_inact_q) | (vsync != vs_inact_q));

  // Sync levels at the start of active video are taken as the inactive levels.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hs_inact_q <= 1'b0;
      vs_inact_q <= 1'b0;
    end else if (de_rise) begin
      hs_inact_q <= hsync;
      vs_inact_q <= vsync;
    end
  end
`else
  assign hs_act      = hsync;
  assign hs_act_prev = hs_q;
  assign vs_act      = vsync;
  assign vs_act_prev = vs_q;
  assign pol_change  = 1'b0;
`endif

  assign de_fall       = ~de & de_q;
  assign hs_edge       = hs_act & ~hs_act_prev;
  assign vs_edge       = vs_act & ~vs_act_prev;
  assign glitch        = hs_edge & de;
  assign ovf           = (de & de_q & (x == MaxCnt)) | (de_fall & (y == MaxCnt));
  assign line_len      = x + One;
  // A line ending on the vsync edge still belongs to the frame being closed.
  assign lines         = y + {{(WIDTH-1){1'b0}}, de_fall};
  assign frame_h       = cur_vld_q ? cur_h_q : line_len;
  assign line_bad      = glitch | (de_fall & cur_vld_q & (line_len != cur_h_q));
  assign lock_line_bad = glitch | (de_fall & (line_len != h_active));
  assign frame_match   = cur_ok_q & ~line_bad & (lines != '0) & (lines == v_active) &
                         (frame_h == h_active);

  always_comb begin
    x_d = '0;
    if (de && de_q) x_d = (x == MaxCnt) ? x : x + One;
    y_d = y;
    if (vs_edge)                     y_d = '0;
    else if (de_fall && y != MaxCnt) y_d = y + One;
  end

  always_comb begin
    cur_h_d   = cur_h_q;
    cur_vld_d = cur_vld_q;
    cur_ok_d  = cur_ok_q & ~line_bad;
    if (de_fall && !cur_vld_q) begin
      cur_h_d   = line_len;
      cur_vld_d = 1'b1;
    end
    if (vs_edge) begin
      cur_vld_d = 1'b0;
      cur_ok_d  = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    match_d    = match_q;
    h_act_d    = h_active;
    v_act_d    = v_active;
    lock_err_d = 1'b0;
    unique case (state_q)
      StSearch: if (vs_edge) state_d = StMeasure;
      StMeasure: begin
        if (line_bad) begin
          state_d = StSearch;
        end else if (vs_edge && lines != '0) begin
          h_act_d = frame_h;
          v_act_d = lines;
          match_d = 4'd1;
          state_d = (LockFrames == 4'd1) ? StLocked : StCheck;
        end
      end
      StCheck: begin
        if (vs_edge) begin
          if (frame_match) begin
            match_d = match_q + 4'd1;
            if (match_d >= LockFrames) state_d = StLocked;
          end else begin
            if (lines != '0) h_act_d = frame_h;
            v_act_d = lines;
            match_d = 4'd1;
          end
        end
      end
      StLocked: begin
        if (lock_line_bad || pol_change ||
            (vs_edge && (lines == '0 || lines != v_active))) begin
          state_d    = StSearch;
          lock_err_d = 1'b1;
        end
      end
      default: state_d = StSearch;
    endcase
    if (ovf) begin
      state_d    = StSearch;
      lock_err_d = (state_q == StLocked);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      x           <= '0;
      y           <= '0;
      h_active    <= '0;
      v_active    <= '0;
      state_q     <= StSearch;
      match_q     <= '0;
      cur_h_q     <= '0;
      cur_vld_q   <= 1'b0;
      cur_ok_q    <= 1'b1;
      locked      <= 1'b0;
      frame_start <= 1'b0;
      lock_err    <= 1'b0;
    end else begin
      de_q        <= de;
      hs_q        <= hsync;
      vs_q        <= vsync;
      x           <= x_d;
      y           <= y_d;
      h_active    <= h_act_d;
      v_active    <= v_act_d;
      state_q     <= state_d;
      match_q     <= match_d;
      cur_h_q     <= cur_h_d;
      cur_vld_q   <= cur_vld_d;
      cur_ok_q    <= cur_ok_d;
      locked      <= (state_d == StLocked);
      frame_start <= vs_edge;
      lock_err    <= lock_err_d;
    end
  end

endmodule

// File: tb/tb_video_timing_decoder.sv
// Bench for video_timing_decoder: frame-level queue model checked every cycle plus directed literals.
module tb_video_timing_decoder;

  localparam int LF = 2;

  logic        clk, rst, de, hsync, vsync;
  logic [11:0] x, y, h_active, v_active;
  logic        locked, frame_start, lock_err;
  logic        hpol, vpol;

  int n_pass = 0, n_total = 0, err_pulses = 0, e0;

  video_timing_decoder #(.WIDTH(12), .LOCK_FRAMES(LF)) dut (
    .clk(clk), .rst(rst), .de(de), .hsync(hsync), .vsync(vsync), .x(x), .y(y),
    .h_active(h_active), .v_active(v_active), .locked(locked),
    .frame_start(frame_start), .lock_err(lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Model: lines of the current frame are kept as a queue of lengths; lock decisions are
  // made on whole lines and whole frames. mode: 0 search, 1 measure, 2 check, 3 locked.
  int  m_mode, m_run, m_h, m_v, m_cnt, m_len, m_n;
  int  m_lens[$];
  bit  m_glitch, p_de, p_hs, p_vs, h_in, v_in;
  bit  s_fall, s_rise, s_vse, s_hse, s_gl, s_bad, s_uni, s_pol;
  int  e_x, e_y, e_h, e_v;
  bit  e_lock, e_fs, e_err;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_mode = 0; m_run = 0; m_h = 0; m_v = 0; m_cnt = 0; m_lens.delete(); m_glitch = 0;
      p_de = 0; p_hs = 0; p_vs = 0; h_in = 0; v_in = 0;
      e_x = 0; e_y = 0; e_h = 0; e_v = 0; e_lock = 0; e_fs = 0; e_err = 0;
    end else begin
      s_fall = p_de && !de;
      s_rise = de && !p_de;
`ifdef VTD_POLARITY_DETECT_EN
      s_vse = ((vsync ^ v_in) == 1'b1) && ((p_vs ^ v_in) == 1'b0);
      s_hse = ((hsync ^ h_in) == 1'b1) && ((p_hs ^ h_in) == 1'b0);
      s_pol = s_rise && (hsync != h_in || vsync != v_in);
      if (s_rise) begin h_in = hsync; v_in = vsync; end
`else
      s_vse = vsync && !p_vs;
      s_hse = hsync && !p_hs;
      s_pol = 0;
`endif
      s_gl  = s_hse && de;
      m_len = m_run;
      if (de) m_run = p_de ? m_run + 1 : 1;
      s_bad = s_gl || (s_fall && m_lens.size() > 0 && m_len != m_lens[0]);
      if (s_fall) m_lens.push_back(m_len);
      if (s_gl) m_glitch = 1;
      m_n   = m_lens.size();
      s_uni = !m_glitch;
      foreach (m_lens[i]) if (m_lens[i] != m_lens[0]) s_uni = 0;
      e_err = 0;
      case (m_mode)
        0: if (s_vse) m_mode = 1;
        1: if (s_bad) m_mode = 0;
           else if (s_vse && m_n > 0) begin
             m_h = m_lens[0]; m_v = m_n; m_cnt = 1; m_mode = (LF == 1) ? 3 : 2;
           end
        2: if (s_vse) begin
             if (s_uni && m_n > 0 && m_n == m_v && m_lens[0] == m_h) begin
               m_cnt++;
               if (m_cnt >= LF) m_mode = 3;
             end else begin
               if (m_n > 0) m_h = m_lens[0];
               m_v = m_n; m_cnt = 1;
             end
           end
        default: if ((s_fall && m_len != m_h) || s_gl || s_pol ||
                     (s_vse && (m_n == 0 || m_n != m_v))) begin
                   m_mode = 0; e_err = 1;
                 end
      endcase
      if (s_vse) begin m_lens.delete(); m_glitch = 0; end
      e_x = de ? m_run - 1 : 0;
      e_y = m_lens.size();
      e_h = m_h; e_v = m_v; e_lock = (m_mode == 3); e_fs = s_vse;
      p_de = de; p_hs = hsync; p_vs = vsync;
    end
  end

  always @(negedge clk) begin
    chk("x", x, e_x);
    chk("y", y, e_y);
    chk("h_active", h_active, e_h);
    chk("v_active", v_active, e_v);
    chk("locked", locked, e_lock);
    chk("frame_start", frame_start, e_fs);
    chk("lock_err", lock_err, e_err);
    if (lock_err) err_pulses++;
  end

  task automatic drive(input logic d, input logic h, input logic v);
    de = d; hsync = h ^ hpol; vsync = v ^ vpol;
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int len);
    drive(0, 1, 0);
    drive(0, 0, 0);
    repeat (len) drive(1, 0, 0);
  endtask

  task automatic vsync_blk();
    drive(0, 0, 1); drive(0, 0, 1); drive(0, 0, 0); drive(0, 0, 0);
  endtask

  // Frame of n lines; line bad_idx gets bad_len pixels; simul makes the last de fall with vsync.
  task automatic frame(input int n, input int bad_idx, input int bad_len, input bit simul);
    for (int i = 0; i < n; i++) begin
      line((i == bad_idx) ? bad_len : 8);
      if (!(simul && i == n - 1)) drive(0, 0, 0);
    end
    vsync_blk();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_h"}, h_active, 0);
    chk({tag, "_v"}, v_active, 0);
    chk({tag, "_locked"}, locked, 0);
  endtask

  initial begin
    rst = 1; de = 0; hsync = 0; vsync = 0; hpol = 0; vpol = 0;
    #2 rst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1;
    repeat (3) drive(0, 0, 0);

    // Nominal lock on 8x4 frames.
    frame(4, -1, 0, 0);
    frame(4, -1, 0, 0);
    chk("meas_h", h_active, 8);
    chk("meas_v", v_active, 4);
    chk("meas_locked", locked, 0);
    frame(4, -1, 0, 0);
    chk("nominal_locked", locked, 1);
    line(8);
    chk("x_last_pixel", x, 7);
    chk("y_first_line", y, 0);
    drive(0, 0, 0);
    chk("x_blank", x, 0);
    chk("y_second_line", y, 1);
    for (int i = 0; i < 3; i++) begin line(8); drive(0, 0, 0); end
    vsync_blk();
    chk("still_locked", locked, 1);

    // Short line while locked, then relock.
    e0 = err_pulses;
    frame(4, 2, 7, 0);
    chk("glitch_err_pulses", err_pulses - e0, 1);
    chk("glitch_locked", locked, 0);
    frame(4, -1, 0, 0);
    chk("relock_pending", locked, 0);
    frame(4, -1, 0, 0);
    chk("relock", locked, 1);

    // Geometry change while in CHECK.
    frame(4, 1, 7, 0);
    frame(4, -1, 0, 0);
    chk("check_v", v_active, 4);
    frame(5, -1, 0, 0);
    chk("resize_v", v_active, 5);
    chk("resize_locked", locked, 0);
    frame(5, -1, 0, 0);
    chk("resize_relock", locked, 1);

    // de falling on the vsync edge counts the ending line.
    e0 = err_pulses;
    repeat (3) frame(4, -1, 0, 1);
    chk("simul_v", v_active, 4);
    chk("simul_h", h_active, 8);
    chk("simul_err_pulses", err_pulses - e0, 1);
    frame(4, -1, 0, 1);
    chk("simul_locked", locked, 1);

    // Reset in the middle of a line.
    drive(0, 1, 0); drive(0, 0, 0);
    repeat (4) drive(1, 0, 0);
    rst = 0;
    repeat (3) drive(1, 0, 0);
    chk_zero("midreset");
    rst = 1;
    repeat (4) drive(1, 0, 0);
    drive(0, 0, 0);
    line(8); drive(0, 0, 0);
    vsync_blk();
    chk("post_reset_locked_a", locked, 0);
    frame(4, -1, 0, 0);
    chk("post_reset_locked_b", locked, 0);
    frame(4, -1, 0, 0);
    chk("post_reset_locked_c", locked, 1);

`ifdef VTD_POLARITY_DETECT_EN
    hpol = 1; vpol = 1;
    repeat (4) frame(4, -1, 0, 0);
    chk("pol_low_locked", locked, 1);
    e0 = err_pulses;
    vpol = 0;
    frame(4, -1, 0, 0);
    chk("pol_flip_err", err_pulses - e0, 1);
    chk("pol_flip_locked", locked, 0);
    repeat (3) frame(4, -1, 0, 0);
    chk("pol_relock", locked, 1);
`endif

    repeat (2) drive(0, 0, 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
